// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with flush, bubble insertion and stall counter.
// Latency: 1 cycle from accept to out_*; in_ready comes straight from the skid valid flop.
// Backpressure: out_ready=0 parks one extra entry in skid, then in_ready drops until a release.
module pipe_stage_reg #(
    parameter int                CTRL_W = 12,
    parameter int                DATA_W = 122,
    parameter logic [CTRL_W-1:0] BUBBLE = {CTRL_W{1'b0}},
    parameter int                CNT_W  = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           main_q;
    entry_t           skid_q;
    entry_t           in_e;
    logic             main_vld;
    logic             skid_vld;
    logic [CNT_W-1:0] stall_q;
    logic             accept;
    logic             rel;
    logic             stall_evt;

    assign in_e      = '{ctrl: in_ctrl, data: in_data};
    // skid_vld is a flop, so in_ready never sees out_ready combinationally
    assign in_ready  = ~skid_vld;
    assign accept    = in_valid & in_ready;
    assign rel       = main_vld & out_ready;
    assign stall_evt = main_vld & ~out_ready;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
            stall_q  <= '0;
        end else begin
            if (stall_evt && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};

            if (flush) begin
                main_vld <= 1'b0;
                skid_vld <= 1'b0;
            end else if (rel && skid_vld) begin
                main_q   <= skid_q;
                skid_vld <= 1'b0;
            end else if (rel) begin
                main_vld <= accept;
                if (accept)
                    main_q <= in_e;
            end else if (accept) begin
                if (main_vld) begin
                    skid_q   <= in_e;
                    skid_vld <= 1'b1;
                end else begin
                    main_q   <= in_e;
                    main_vld <= 1'b1;
                end
            end
        end
    end

    // Invalidated entries keep stale data; only the control field is masked.
    assign out_valid = main_vld;
    assign out_ctrl  = main_vld ? main_q.ctrl : BUBBLE;
    assign out_data  = main_q.data;
    assign occupancy = {skid_vld, main_vld & ~skid_vld};
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized scoreboard bench for pipe_stage_reg, plus a CNT_W=2 instance for saturation.
module tb_pipe_stage_reg;
    localparam int CW = 12;
    localparam int DW = 122;
    localparam logic [CW-1:0] BUB = 12'hB0B;

    logic          clock;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    logic          in_ready2, out_valid2;
    logic [CW-1:0] out_ctrl2;
    logic [DW-1:0] out_data2;
    logic [1:0]    occupancy2;
    logic [1:0]    stall_cnt2;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .BUBBLE(BUB), .CNT_W(16)) dut (
        .clock(clock), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(2)) dut2 (
        .clock(clock), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2), .out_data(out_data2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    logic [CW+DW-1:0] exp_q[$];
    int held_n = 0;
    int stall_n = 0;
    logic last_acc = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [CW+DW-1:0] act, input logic [CW+DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic check_state();
        chk("occupancy", int'(occupancy), held_n);
        chk("in_ready", int'(in_ready), int'(held_n < 2));
        chk("out_valid", int'(out_valid), int'(held_n > 0));
        if (!out_valid) chk("bubble", int'(out_ctrl), int'(BUB));
        chk("stall_cnt", int'(stall_cnt), (stall_n > 65535) ? 65535 : stall_n);
        chk("stall_cnt_w2", int'(stall_cnt2), (stall_n > 3) ? 3 : stall_n);
    endtask

    task automatic reset_checks();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_out_ctrl", int'(out_ctrl), int'(BUB));
        chkw("rst_out_data", {{CW{1'b0}}, out_data}, '0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_stall_cnt_w2", int'(stall_cnt2), 0);
    endtask

    // Reference: the stage holds up to two entries in arrival order; flush empties it.
    task automatic step(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                        input logic ordy, input logic fl);
        logic rel, acc;
        in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy; flush = fl;
        @(posedge clock);
        rel = (held_n > 0) && ordy;
        acc = iv && (held_n < 2);
        if ((held_n > 0) && !ordy) stall_n++;
        if (fl) begin
            held_n = 0;
            exp_q.delete();
        end else begin
            held_n = held_n - int'(rel) + int'(acc);
            if (acc) exp_q.push_back({ic, id});
        end
        last_acc = acc && !fl;
        #1 check_state();
        @(negedge clock);
    endtask

    task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
        int n;
        n = 0;
        do begin
            step(1'b1, c, d, ordy, 1'b0);
            n++;
        end while (!last_acc && n < 20);
        chk("offer_accepted", int'(last_acc), 1);
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, ordy, 1'b0);
    endtask

    // Monitor: checks the head against the scoreboard and retires it on a handshake.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", 1, 0);
                end else begin
                    chkw("head_entry", {out_ctrl, out_data}, exp_q[0]);
                    if (out_ready && !flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1 reset_checks();
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        idle(1'b1, 2);

        for (int k = 1; k <= 8; k++) step(1'b1, 12'h5A3, DW'(k), 1'b1, 1'b0);
        idle(1'b1, 2);

        offer(12'hA01, DW'(32'hAAAA), 1'b0);
        offer(12'hB02, DW'(32'hBBBB), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 12'hC03, DW'(32'hCCCC), 1'b0, 1'b0);
        offer(12'hC03, DW'(32'hCCCC), 1'b1);
        idle(1'b1, 3);

        offer(12'h111, DW'(32'h1111), 1'b0);
        offer(12'h222, DW'(32'h2222), 1'b0);
        step(1'b1, 12'hDEA, DW'(32'hDEAD), 1'b0, 1'b1);
        idle(1'b1, 3);

        offer(12'h333, DW'(32'h3333), 1'b0);
        offer(12'h444, DW'(32'h4444), 1'b0);
        #3 rst_n = 1'b0;
        #1 reset_checks();
        held_n = 0; stall_n = 0; exp_q.delete();
        @(negedge clock);
        rst_n = 1'b1;
        idle(1'b1, 2);

        offer(12'h555, DW'(32'h5555), 1'b0);
        idle(1'b0, 6);
        idle(1'b1, 2);

        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), 12'($urandom), rnd_data(),
                 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) == 0));
        idle(1'b1, 4);
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
